// File: rtl/sram_master_pkg.sv
// rtl/sram_master_pkg.sv - shared types and defaults for the SRAM fill/check master
// Purpose: op encoding, FSM state encoding and default bus widths used by
//          sram_fill_check_master and sram_rd_pipe.
// Ports:   none (package)
package sram_master_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OP_FILL   = 1'b0,
    OP_VERIFY = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - read-latency matching pipe for issued SRAM reads
// Purpose: carries {valid, expected word, address} of each issued read for
//          LATENCY cycles so it lines up with the returning read data.
// Ports:   i_clk, i_rst_n (async active-low, clears every stage)
//          i_valid/i_exp/i_addr : entry pushed this cycle
//          o_valid/o_exp/o_addr : entry issued LATENCY cycles ago
module sram_rd_pipe
  import sram_master_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_exp,
  output logic [ADDR_W-1:0] o_addr
);

  logic [LATENCY-1:0]             r_valid;
  logic [LATENCY-1:0][DATA_W-1:0] r_exp;
  logic [LATENCY-1:0][ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_exp   <= '0;
      r_addr  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_exp[0]   <= i_exp;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_exp[i]   <= r_exp[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_exp   = r_exp[LATENCY-1];
  assign o_addr  = r_addr[LATENCY-1];

endmodule

// File: rtl/sram_fill_check_master.sv
// rtl/sram_fill_check_master.sv - Avalon-MM SRAM fill / verify engine
// Purpose: executes one FILL or VERIFY command at a time over a word range of
//          the on-chip SRAM, one access per cycle, counting VERIFY mismatches.
// Ports:   clk, reset_n (async active-low)
//          start/op/base_addr/length/pattern/incr : command, taken when idle
//          busy/done                              : command status
//          err_count/first_err_valid/first_err_addr : VERIFY results
//          m_* : Avalon-MM host port toward the SRAM slave
module sram_fill_check_master
  import sram_master_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                op,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         length,
  input  logic [DATA_W-1:0]   pattern,
  input  logic                incr,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
);

  state_e              r_state;
  state_e              w_state_nxt;
  op_e                 r_op;
  logic                r_incr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_exp;
  logic [15:0]         r_left;
  logic [1:0]          r_drain;
  logic [15:0]         r_err_count;
  logic                r_first_valid;
  logic [ADDR_W-1:0]   r_first_addr;

  logic                w_accept;
  logic                w_rd_push;
  logic                w_pipe_valid;
  logic [DATA_W-1:0]   w_pipe_exp;
  logic [ADDR_W-1:0]   w_pipe_addr;
  logic                w_mismatch;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_rd_push  = (r_state == S_RUN) && (r_op == OP_VERIFY);
  assign w_mismatch = w_pipe_valid && (m_readdata != w_pipe_exp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus strobes decode straight from the registered state so an async reset
  // drops chipselect in the same instant.
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (length == 16'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        busy         = 1'b1;
        m_chipselect = 1'b1;
        m_write      = (r_op == OP_FILL);
        if (r_left == 16'd1) begin
          w_state_nxt = (r_op == OP_FILL) ? S_FIN : S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_drain == 2'd1) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign m_clken         = busy;
  assign m_address       = r_addr;
  assign m_byteenable    = m_chipselect ? '1 : '0;
  assign m_writedata     = m_write ? r_exp : '0;
  assign err_count       = r_err_count;
  assign first_err_valid = r_first_valid;
  assign first_err_addr  = r_first_addr;

  // Address and expected word advance together; the address wraps naturally
  // at 2^ADDR_W so long commands revisit words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op          <= OP_FILL;
      r_incr        <= 1'b0;
      r_addr        <= '0;
      r_exp         <= '0;
      r_left        <= '0;
      r_drain       <= '0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_op          <= op_e'(op);
        r_incr        <= incr;
        r_addr        <= base_addr;
        r_exp         <= pattern;
        r_left        <= length;
        r_err_count   <= '0;
        r_first_valid <= 1'b0;
        r_first_addr  <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_exp   <= r_exp + DATA_W'(r_incr);
          r_left  <= r_left - 16'd1;
          r_drain <= 2'(READ_LATENCY);
        end else if (r_state == S_DRAIN) begin
          r_drain <= r_drain - 2'd1;
        end
        if (w_mismatch) begin
          if (r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
          end
          if (!r_first_valid) begin
            r_first_valid <= 1'b1;
            r_first_addr  <= w_pipe_addr;
          end
        end
      end
    end
  end

  sram_rd_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_valid (w_rd_push),
    .i_exp   (r_exp),
    .i_addr  (r_addr),
    .o_valid (w_pipe_valid),
    .o_exp   (w_pipe_exp),
    .o_addr  (w_pipe_addr)
  );

endmodule
